regfile_wr_arbiter: RTL and testbench

Arbitrates the single register-file write port between three writers. The pipeline writeback stage has absolute priority. Two secondary requesters, A (multiply/divide writeback) and B (host/debug loader), share the remaining cycles round-robin through valid/ready handshakes. The block sits directly in front of the regfile `in_rd_wena/in_rd_addr/in_rd_data` inputs, drives them from registers, and raises a stall request to the pipeline when the secondaries starve.

---
 rtl/regfile_wr_arbiter.sv | 114 +++++++++++
 tb/tb_regfile_wr_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: pipeline writeback first, then A/B round-robin,
// with a starvation stall request. Define REGFILE_ARB_STATS_EN to build grant counters.
module regfile_wr_arbiter #(
    parameter int STARVE_LIMIT = 16
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_wb_wena,
    input  logic [4:0]  in_wb_addr,
    input  logic [31:0] in_wb_data,
    input  logic        in_a_valid,
    input  logic [4:0]  in_a_addr,
    input  logic [31:0] in_a_data,
    output logic        out_a_ready,
    input  logic        in_b_valid,
    input  logic [4:0]  in_b_addr,
    input  logic [31:0] in_b_data,
    output logic        out_b_ready,
    output logic        out_rd_wena,
    output logic [4:0]  out_rd_addr,
    output logic [31:0] out_rd_data,
    output logic        out_stall_req,
    output logic [15:0] out_grant_cnt_a,
    output logic [15:0] out_grant_cnt_b
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    typedef struct packed {
        logic        vld;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_req_t;

    logic    rr;
    logic    a_xfer, b_xfer, sec_xfer, sec_pend;
    logic [7:0] wait_cnt;
    wr_req_t win;

    // Ready doubles as the transfer strobe since it already includes valid.
    always_comb begin
        out_a_ready = !in_rst && !in_wb_wena && in_a_valid && (!rr || !in_b_valid);
        out_b_ready = !in_rst && !in_wb_wena && in_b_valid && (rr || !in_a_valid);
        a_xfer      = out_a_ready;
        b_xfer      = out_b_ready;
        sec_xfer    = a_xfer || b_xfer;
        sec_pend    = in_a_valid || in_b_valid;
        win         = '0;
        if (in_wb_wena)
            win = '{vld: 1'b1, addr: in_wb_addr, data: in_wb_data};
        else if (a_xfer)
            win = '{vld: 1'b1, addr: in_a_addr, data: in_a_data};
        else if (b_xfer)
            win = '{vld: 1'b1, addr: in_b_addr, data: in_b_data};
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            out_rd_wena <= 1'b0;
            out_rd_addr <= '0;
            out_rd_data <= '0;
        end else begin
            // r0 writes still complete the handshake but never reach the array.
            out_rd_wena <= win.vld && (win.addr != 5'd0);
            if (win.vld) begin
                out_rd_addr <= win.addr;
                out_rd_data <= win.data;
            end
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            rr            <= 1'b0;
            wait_cnt      <= '0;
            out_stall_req <= 1'b0;
        end else begin
            if (a_xfer)
                rr <= 1'b1;
            else if (b_xfer)
                rr <= 1'b0;

            if (sec_xfer || !sec_pend)
                wait_cnt <= '0;
            else if (wait_cnt != LIMIT)
                wait_cnt <= wait_cnt + 8'd1;

            out_stall_req <= (wait_cnt == LIMIT) && sec_pend && !sec_xfer;
        end
    end

`ifdef REGFILE_ARB_STATS_EN
    logic [15:0] cnt_a, cnt_b;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (a_xfer && cnt_a != 16'hFFFF)
                cnt_a <= cnt_a + 16'd1;
            if (b_xfer && cnt_b != 16'hFFFF)
                cnt_b <= cnt_b + 16'd1;
        end
    end

    assign out_grant_cnt_a = cnt_a;
    assign out_grant_cnt_b = cnt_b;
`else
    assign out_grant_cnt_a = '0;
    assign out_grant_cnt_b = '0;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with a small regfile model behind out_rd_*.
module tb_regfile_wr_arbiter;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic        in_wb_wena;
    logic [4:0]  in_wb_addr;
    logic [31:0] in_wb_data;
    logic        in_a_valid;
    logic [4:0]  in_a_addr;
    logic [31:0] in_a_data;
    logic        out_a_ready;
    logic        in_b_valid;
    logic [4:0]  in_b_addr;
    logic [31:0] in_b_data;
    logic        out_b_ready;
    logic        out_rd_wena;
    logic [4:0]  out_rd_addr;
    logic [31:0] out_rd_data;
    logic        out_stall_req;
    logic [15:0] out_grant_cnt_a;
    logic [15:0] out_grant_cnt_b;

    int total = 0;
    int bad   = 0;

    logic [31:0] regs [32] = '{default: '0};

    regfile_wr_arbiter #(.STARVE_LIMIT(16)) dut (
        .in_clk(in_clk), .in_rst(in_rst),
        .in_wb_wena(in_wb_wena), .in_wb_addr(in_wb_addr), .in_wb_data(in_wb_data),
        .in_a_valid(in_a_valid), .in_a_addr(in_a_addr), .in_a_data(in_a_data),
        .out_a_ready(out_a_ready),
        .in_b_valid(in_b_valid), .in_b_addr(in_b_addr), .in_b_data(in_b_data),
        .out_b_ready(out_b_ready),
        .out_rd_wena(out_rd_wena), .out_rd_addr(out_rd_addr), .out_rd_data(out_rd_data),
        .out_stall_req(out_stall_req),
        .out_grant_cnt_a(out_grant_cnt_a), .out_grant_cnt_b(out_grant_cnt_b)
    );

    always #5 in_clk = ~in_clk;

    // Regfile array as the arbiter sees it: writes land one edge after out_rd_*.
    always @(posedge in_clk)
        if (out_rd_wena && out_rd_addr != 5'd0)
            regs[out_rd_addr] <= out_rd_data;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    logic [15:0] exp_cnt_a, exp_cnt_b;

    initial begin
        in_rst = 1'b1;
        in_wb_wena = 0; in_wb_addr = 0; in_wb_data = 0;
        in_a_valid = 1; in_a_addr = 5'd9; in_a_data = 32'h9;
        in_b_valid = 0; in_b_addr = 0; in_b_data = 0;
        repeat (2) tick();
        chk("rst_wena",  32'(out_rd_wena), 0);
        chk("rst_addr",  32'(out_rd_addr), 0);
        chk("rst_data",  out_rd_data, 0);
        chk("rst_stall", 32'(out_stall_req), 0);
        chk("rst_cnt_a", 32'(out_grant_cnt_a), 0);
        chk("rst_cnt_b", 32'(out_grant_cnt_b), 0);
        chk("rst_a_rdy", 32'(out_a_ready), 0);
        in_a_valid = 0;
        in_rst = 1'b0;
        tick();

        // Writeback only
        in_wb_wena = 1; in_wb_addr = 5'd5; in_wb_data = 32'h1234;
        tick();
        in_wb_wena = 0;
        chk("wb_wena", 32'(out_rd_wena), 1);
        chk("wb_addr", 32'(out_rd_addr), 5);
        chk("wb_data", out_rd_data, 32'h1234);
        tick();
        chk("wb_r5",   regs[5], 32'h1234);
        chk("wb_idle", 32'(out_rd_wena), 0);

        // A and B contend: A first after reset, then alternate
        in_a_valid = 1; in_a_addr = 5'd1; in_a_data = 32'hA1;
        in_b_valid = 1; in_b_addr = 5'd2; in_b_data = 32'hB2;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rr_one_rdy", 32'(out_a_ready) + 32'(out_b_ready), 1);
            chk("rr_a_rdy",   32'(out_a_ready), (i % 2 == 0) ? 1 : 0);
            tick();
            chk("rr_addr",    32'(out_rd_addr), (i % 2 == 0) ? 1 : 2);
            chk("rr_data",    out_rd_data, (i % 2 == 0) ? 32'hA1 : 32'hB2);
        end
        in_a_valid = 0; in_b_valid = 0;
        tick();
        chk("rr_r1", regs[1], 32'hA1);
        chk("rr_r2", regs[2], 32'hB2);

        // Starvation: WB blocks A for 20 cycles
        in_wb_wena = 1; in_wb_addr = 5'd3; in_wb_data = 32'h3;
        in_a_valid = 1; in_a_addr = 5'd4; in_a_data = 32'h44;
        #1;
        chk("st_a_blocked", 32'(out_a_ready), 0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 16) chk("st_stall_16", 32'(out_stall_req), 0);
            if (i == 17) chk("st_stall_17", 32'(out_stall_req), 1);
        end
        chk("st_stall_20", 32'(out_stall_req), 1);
        in_wb_wena = 0;
        #1;
        chk("st_a_rdy", 32'(out_a_ready), 1);
        tick();
        in_a_valid = 0;
        chk("st_clear",  32'(out_stall_req), 0);
        chk("st_addr",   32'(out_rd_addr), 4);
        chk("st_data",   out_rd_data, 32'h44);

        // B writes r0: handshake completes, write dropped
        in_b_valid = 1; in_b_addr = 5'd0; in_b_data = 32'hFFFF_FFFF;
        #1;
        chk("r0_b_rdy", 32'(out_b_ready), 1);
        tick();
        in_b_valid = 0;
        chk("r0_wena", 32'(out_rd_wena), 0);
        tick();
        chk("r0_reg", regs[0], 0);

        // Reset while an A write sits registered
        in_a_valid = 1; in_a_addr = 5'd7; in_a_data = 32'h77;
        tick();
        chk("mr_wena_pre", 32'(out_rd_wena), 1);
        in_a_addr = 5'd8; in_a_data = 32'h88;
        in_rst = 1'b1;
        #1;
        chk("mr_wena_rst", 32'(out_rd_wena), 0);
        chk("mr_a_rdy",    32'(out_a_ready), 0);
        chk("mr_cnt_a",    32'(out_grant_cnt_a), 0);
        tick();
        in_rst = 1'b0;
        #1;
        chk("mr_a_rdy_rel", 32'(out_a_ready), 1);
        tick();
        in_a_valid = 0;
        chk("mr_wena", 32'(out_rd_wena), 1);
        chk("mr_addr", 32'(out_rd_addr), 8);
        tick();
        chk("mr_r8", regs[8], 32'h88);
        chk("mr_r7_lost", regs[7], 0);

        // rr=1 after the A transfer: B,A,B,A -> totals A=3, B=2
        in_a_valid = 1; in_a_addr = 5'd10; in_a_data = 32'hAA;
        in_b_valid = 1; in_b_addr = 5'd11; in_b_data = 32'hBB;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("cn_b_rdy", 32'(out_b_ready), (i % 2 == 0) ? 1 : 0);
            tick();
        end
        in_a_valid = 0; in_b_valid = 0;
`ifdef REGFILE_ARB_STATS_EN
        exp_cnt_a = 16'd3; exp_cnt_b = 16'd2;
`else
        exp_cnt_a = 16'd0; exp_cnt_b = 16'd0;
`endif
        tick();
        chk("cnt_a", 32'(out_grant_cnt_a), 32'(exp_cnt_a));
        chk("cnt_b", 32'(out_grant_cnt_b), 32'(exp_cnt_b));
        chk("cn_r11", regs[11], 32'hBB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
